spi_slave: RTL and testbench

//   SPI mode-0 target (slave) sitting at the far end of the SCLK that the 5 MHz clock divider produces.
//   It runs entirely in the clk_100mhz domain: SCLK, CS_N and MOSI are oversampled, synchronised and edge-detected.

---
 rtl/spi_slave.sv | 164 ++++++++++++++++
 tb/tb_spi_slave.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 target running entirely in the clk_100mhz domain.
// SCLK, CS_N and MOSI are oversampled through SYNC_STG flops and edge-detected.
// Received words are reported with a one-cycle rx_valid pulse. Response words
// enter a one-word valid/ready buffer and are shifted out on MISO, MSB first.
// Ports:
//   clk_100mhz, reset (sync, active high)
//   sclk, cs_n, mosi  - asynchronous SPI pins from the master
//   miso              - slave data out, 0 while deselected
//   tx_data/tx_valid/tx_ready - response word handshake (ready = buffer empty)
//   rx_data/rx_valid  - last complete word and its update pulse
//   tx_underrun       - pulse: a word was loaded for shift-out from an empty buffer
//   frame_abort       - pulse: cs_n rose with a partial word
module spi_slave #(
  parameter int DATA_W   = 8,
  parameter int SYNC_STG = 2
) (
  input  logic              clk_100mhz,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STG-1:0] sclk_sr, cs_sr, mosi_sr;
  logic                sclk_d, cs_d;
  logic                sclk_s, cs_s, mosi_s;
  logic                sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                load_pend;
  logic [DATA_W-1:0]   rx_shift, rx_next;
  logic [DATA_W-1:0]   tx_shift, tx_buf, load_word;
  logic                load_now;

  // Synchronisers preset to the idle bus (sclk low, cs_n high) so reset never
  // fabricates an edge on its own.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      sclk_sr <= '0;
      cs_sr   <= '1;
      mosi_sr <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b1;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STG-2:0], sclk};
      cs_sr   <= {cs_sr[SYNC_STG-2:0], cs_n};
      mosi_sr <= {mosi_sr[SYNC_STG-2:0], mosi};
      sclk_d  <= sclk_sr[SYNC_STG-1];
      cs_d    <= cs_sr[SYNC_STG-1];
    end
  end

  always_comb begin
    sclk_s    = sclk_sr[SYNC_STG-1];
    cs_s      = cs_sr[SYNC_STG-1];
    mosi_s    = mosi_sr[SYNC_STG-1];
    sclk_rise = sclk_s & ~sclk_d;
    sclk_fall = ~sclk_s & sclk_d;
    cs_rise   = cs_s & ~cs_d;
    cs_fall   = ~cs_s & cs_d;
    rx_next   = {rx_shift[DATA_W-2:0], mosi_s};
    // Empty buffer means zeros go out (and an underrun is flagged).
    load_word = tx_ready ? '0 : tx_buf;
    load_now  = 1'b0;
    case (state)
      IDLE:    load_now = cs_fall;
      // cs_n rise has priority over any sclk edge in the same cycle
      ACTIVE:  load_now = ~cs_rise & sclk_fall & load_pend;
      default: load_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      load_pend   <= 1'b0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      tx_ready    <= 1'b1;
      miso        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      // Load and accept in one cycle: the load sees the old buffer state,
      // the buffer keeps the newly accepted word.
      if (tx_valid && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else if (load_now) begin
        tx_ready <= 1'b1;
      end

      if (load_now) begin
        tx_shift    <= load_word;
        miso        <= load_word[DATA_W-1];
        tx_underrun <= tx_ready;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= ACTIVE;
            cnt       <= '0;
            load_pend <= 1'b0;
          end else begin
            miso <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            miso        <= 1'b0;
            load_pend   <= 1'b0;
            cnt         <= '0;
            frame_abort <= (cnt != '0);
          end else if (sclk_rise) begin
            rx_shift <= rx_next;
            if (cnt == LAST) begin
              rx_data   <= rx_next;
              rx_valid  <= 1'b1;
              cnt       <= '0;
              load_pend <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            // After a completed word the falling edge loads the next word
            // instead of shifting.
            if (load_pend) begin
              load_pend <= 1'b0;
            end else begin
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              miso     <= tx_shift[DATA_W-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       clk_100mhz = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, frame_abort;

  spi_slave #(.DATA_W(8), .SYNC_STG(2)) dut (
    .clk_100mhz(clk_100mhz), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .frame_abort(frame_abort)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_chk = 0, n_fail = 0;
  int got_under = 0, got_abort = 0;

  // Reference model: one-word buffer, word currently being shifted, event counts.
  logic [7:0] exp_rx_q[$];
  bit         mdl_buf_v = 0;
  logic [7:0] mdl_buf = '0;
  logic [7:0] mdl_shift = '0;
  int         exp_under = 0, exp_abort = 0;
  int         hp = 10;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic clkn(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask

  // Monitor: pops the rx scoreboard on every rx_valid, counts pulses.
  always @(negedge clk_100mhz) begin
    if (!reset) begin
      if (rx_valid) begin
        if (exp_rx_q.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
        else check("rx_word", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
      end
      if (tx_underrun) got_under++;
      if (frame_abort) got_abort++;
    end
  end

  task automatic mdl_load();
    if (mdl_buf_v) begin
      mdl_shift = mdl_buf;
      mdl_buf_v = 0;
    end else begin
      mdl_shift = 8'h00;
      exp_under++;
    end
  endtask

  task automatic offer(input logic [7:0] d);
    check("tx_ready_pre_offer", {31'd0, tx_ready}, {31'd0, !mdl_buf_v});
    if (!mdl_buf_v) begin
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk_100mhz);
      #1 tx_valid = 1'b0;
      mdl_buf   = d;
      mdl_buf_v = 1;
      clkn(1);
      check("tx_ready_post_accept", {31'd0, tx_ready}, 32'd0);
    end
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    clkn(hp);
    mdl_load();
    check("tx_ready_after_csfall", {31'd0, tx_ready}, {31'd0, !mdl_buf_v});
  endtask

  task automatic cs_end();
    clkn(hp);
    cs_n = 1'b1;
    clkn(hp + 4);
    check("miso_idle", {31'd0, miso}, 32'd0);
    check("underrun_cnt", got_under, exp_under);
    check("abort_cnt", got_abort, exp_abort);
  endtask

  // Master clocks nbits bits of d; optional offer of od while SCLK is high on bit 2.
  task automatic xfer(input logic [7:0] d, input int nbits, input bit do_offer, input logic [7:0] od);
    logic [7:0] rd;
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[7-i];
      if (i == 7) exp_rx_q.push_back(d);
      clkn(hp);
      sclk = 1'b1;
      rd = {rd[6:0], miso};
      if (do_offer && i == 2) offer(od);
      clkn(hp);
      sclk = 1'b0;
    end
    if (nbits == 8) begin
      check("miso_word", {24'd0, rd}, {24'd0, mdl_shift});
      mdl_load();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"}, {31'd0, miso}, 32'd0);
    check({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_underrun"}, {31'd0, tx_underrun}, 32'd0);
    check({tag, "_abort"}, {31'd0, frame_abort}, 32'd0);
  endtask

  initial begin
    clkn(4);
    check_reset_vals("reset");
    reset = 1'b0;
    clkn(4);

    // 1: single word, buffered response
    offer(8'h3C);
    cs_start();
    xfer(8'hA5, 8, 0, 8'h00);
    cs_end();
    check("t1_rx_data", {24'd0, rx_data}, 32'hA5);

    // 2: back-to-back words with responses accepted mid-word
    offer(8'hC3);
    cs_start();
    xfer(8'h11, 8, 1, 8'h5A);
    xfer(8'h22, 8, 1, 8'h99);
    cs_end();

    // 3: empty buffer at frame start
    cs_start();
    xfer(8'h5E, 8, 0, 8'h00);
    cs_end();

    // 4: abort after 3 bits
    cs_start();
    xfer(8'hFF, 3, 0, 8'h00);
    exp_abort++;
    cs_end();
    check("t4_rx_hold", {24'd0, rx_data}, 32'h5E);

    // 5: reset mid-frame drops the buffered word
    offer(8'h77);
    cs_start();
    xfer(8'h0F, 5, 1, 8'h88);
    reset = 1'b1;
    clkn(1);
    check_reset_vals("midreset");
    cs_n = 1'b1;
    sclk = 1'b0;
    clkn(4);
    reset = 1'b0;
    mdl_buf_v = 0;
    clkn(4);
    check("t5_tx_ready", {31'd0, tx_ready}, 32'd1);
    cs_start();
    xfer(8'h96, 8, 0, 8'h00);
    cs_end();
    check("t5_rx_data", {24'd0, rx_data}, 32'h96);

    // 6: SCLK at clk/8, 8th rise coincident with cs_n rise is ignored
    hp = 4;
    offer(8'h6B);
    cs_start();
    xfer(8'hF0, 7, 0, 8'h00);
    mosi = 1'b0;
    clkn(hp);
    sclk = 1'b1;
    cs_n = 1'b1;
    exp_abort++;
    clkn(hp);
    sclk = 1'b0;
    clkn(8);
    check("t6_abort_cnt", got_abort, exp_abort);
    check("t6_rx_hold", {24'd0, rx_data}, 32'h96);

    // Random frames against the model
    for (int f = 0; f < 8; f++) begin
      int nw;
      hp = $urandom_range(4, 12);
      if ($urandom_range(0, 1) == 1) offer(8'($urandom));
      cs_start();
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++)
        xfer(8'($urandom), 8, bit'($urandom_range(0, 1)), 8'($urandom));
      cs_end();
    end

    clkn(10);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
